// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS main control: opcodes, ALUOp classes,
// branch codes and control-bundle field widths.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRtype    = 6'b000000;
  localparam logic [5:0] OpSpecial2 = 6'b011100;
  localparam logic [5:0] OpSpecial3 = 6'b011111;
  localparam logic [5:0] OpLw       = 6'b100011;
  localparam logic [5:0] OpSw       = 6'b101011;
  localparam logic [5:0] OpBeq      = 6'b000100;
  localparam logic [5:0] OpBne      = 6'b000101;
  localparam logic [5:0] OpAddi     = 6'b001000;
  localparam logic [5:0] OpAndi     = 6'b001100;
  localparam logic [5:0] OpOri      = 6'b001101;
  localparam logic [5:0] OpSlti     = 6'b001010;

  localparam logic [2:0] AluAdd      = 3'b000;
  localparam logic [2:0] AluSub      = 3'b001;
  localparam logic [2:0] AluRtype    = 3'b010;
  localparam logic [2:0] AluAnd      = 3'b011;
  localparam logic [2:0] AluOr       = 3'b100;
  localparam logic [2:0] AluSlt      = 3'b101;
  localparam logic [2:0] AluSpecial2 = 3'b110;

  localparam int unsigned BranchW = 2;
  localparam logic [BranchW-1:0] BrNone = 2'b00;
  localparam logic [BranchW-1:0] BrEq   = 2'b01;
  localparam logic [BranchW-1:0] BrNe   = 2'b10;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: maps the ID-stage opcode to the control bundle
// and flags opcodes it does not recognise.
module ctrl_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    op_i,
  output logic               reg_dst_o,
  output logic               alu_src_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [BranchW-1:0] branch_o,
  output logic               mem_to_reg_o,
  output logic               reg_write_o,
  output logic               illegal_o
);

  always_comb begin
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = ALUOP_W'(AluAdd);
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    branch_o     = BrNone;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    illegal_o    = 1'b0;
    case (op_i)
      OP_W'(OpRtype), OP_W'(OpSpecial3): begin
        reg_dst_o   = 1'b1;
        alu_op_o    = ALUOP_W'(AluRtype);
        reg_write_o = 1'b1;
      end
      OP_W'(OpSpecial2): begin
        reg_dst_o   = 1'b1;
        alu_op_o    = ALUOP_W'(AluSpecial2);
        reg_write_o = 1'b1;
      end
      OP_W'(OpLw): begin
        alu_src_o    = 1'b1;
        mem_read_o   = 1'b1;
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      OP_W'(OpSw): begin
        alu_src_o   = 1'b1;
        mem_write_o = 1'b1;
      end
      OP_W'(OpBeq): begin
        branch_o = BrEq;
        alu_op_o = ALUOP_W'(AluSub);
      end
      OP_W'(OpBne): begin
        branch_o = BrNe;
        alu_op_o = ALUOP_W'(AluSub);
      end
      OP_W'(OpAddi): begin
        alu_src_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      OP_W'(OpAndi): begin
        alu_src_o   = 1'b1;
        reg_write_o = 1'b1;
        alu_op_o    = ALUOP_W'(AluAnd);
      end
      OP_W'(OpOri): begin
        alu_src_o   = 1'b1;
        reg_write_o = 1'b1;
        alu_op_o    = ALUOP_W'(AluOr);
      end
      OP_W'(OpSlti): begin
        alu_src_o   = 1'b1;
        reg_write_o = 1'b1;
        alu_op_o    = ALUOP_W'(AluSlt);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined main control: decodes in ID, carries the bundle through ID/EX, EX/MEM, MEM/WB.
// Load-use stall/bubble insertion is built only when HAZARD_DETECT_EN is defined.
module pipe_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W       = 6,
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [OP_W-1:0]       Op,
  input  logic                  InstrValid,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic                  Flush,
  output logic                  RegDst_EX,
  output logic                  ALUSrc_EX,
  output logic [ALUOP_W-1:0]    ALUOp_EX,
  output logic [REG_ADDR_W-1:0] Rt_EX,
  output logic                  MemRead_MEM,
  output logic                  MemWrite_MEM,
  output logic [BranchW-1:0]    Branch_MEM,
  output logic                  MemtoReg_WB,
  output logic                  RegWrite_WB,
  output logic                  Stall,
  output logic                  IllegalOp
);

  logic                  dec_reg_dst, dec_alu_src, dec_mem_read, dec_mem_write;
  logic                  dec_mem_to_reg, dec_reg_write, dec_illegal;
  logic [ALUOP_W-1:0]    dec_alu_op;
  logic [BranchW-1:0]    dec_branch;

  ctrl_decoder #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_decoder (
    .op_i         (Op),
    .reg_dst_o    (dec_reg_dst),
    .alu_src_o    (dec_alu_src),
    .alu_op_o     (dec_alu_op),
    .mem_read_o   (dec_mem_read),
    .mem_write_o  (dec_mem_write),
    .branch_o     (dec_branch),
    .mem_to_reg_o (dec_mem_to_reg),
    .reg_write_o  (dec_reg_write),
    .illegal_o    (dec_illegal)
  );

  // ID/EX
  logic                  reg_dst_ex_d, reg_dst_ex_q, alu_src_ex_d, alu_src_ex_q;
  logic [ALUOP_W-1:0]    alu_op_ex_d, alu_op_ex_q;
  logic [REG_ADDR_W-1:0] rt_ex_d, rt_ex_q;
  logic                  mem_read_ex_d, mem_read_ex_q, mem_write_ex_d, mem_write_ex_q;
  logic [BranchW-1:0]    branch_ex_d, branch_ex_q;
  logic                  mem_to_reg_ex_d, mem_to_reg_ex_q, reg_write_ex_d, reg_write_ex_q;
  logic                  illegal_ex_d, illegal_ex_q;
  // EX/MEM
  logic                  mem_read_mem_d, mem_read_mem_q, mem_write_mem_d, mem_write_mem_q;
  logic [BranchW-1:0]    branch_mem_d, branch_mem_q;
  logic                  mem_to_reg_mem_d, mem_to_reg_mem_q, reg_write_mem_d, reg_write_mem_q;
  // MEM/WB
  logic                  mem_to_reg_wb_d, mem_to_reg_wb_q, reg_write_wb_d, reg_write_wb_q;

  logic load_use, id_kill;

`ifdef HAZARD_DETECT_EN
  // Flush outranks the hazard: the stalled instruction is being squashed anyway.
  always_comb begin
    load_use = !Rst && InstrValid && !Flush && mem_read_ex_q && (rt_ex_q != '0) &&
               ((rt_ex_q == Rs_ID) || (rt_ex_q == Rt_ID));
  end
`else
  logic unused_rs;
  assign unused_rs = ^Rs_ID;
  always_comb begin
    load_use = 1'b0;
  end
`endif

  always_comb begin
    id_kill          = !InstrValid || Flush || load_use;
    reg_dst_ex_d     = id_kill ? 1'b0 : dec_reg_dst;
    alu_src_ex_d     = id_kill ? 1'b0 : dec_alu_src;
    alu_op_ex_d      = id_kill ? '0   : dec_alu_op;
    rt_ex_d          = id_kill ? '0   : Rt_ID;
    mem_read_ex_d    = id_kill ? 1'b0 : dec_mem_read;
    mem_write_ex_d   = id_kill ? 1'b0 : dec_mem_write;
    branch_ex_d      = id_kill ? '0   : dec_branch;
    mem_to_reg_ex_d  = id_kill ? 1'b0 : dec_mem_to_reg;
    reg_write_ex_d   = id_kill ? 1'b0 : dec_reg_write;
    illegal_ex_d     = !id_kill && dec_illegal;
    mem_read_mem_d   = mem_read_ex_q;
    mem_write_mem_d  = mem_write_ex_q;
    branch_mem_d     = branch_ex_q;
    mem_to_reg_mem_d = mem_to_reg_ex_q;
    reg_write_mem_d  = reg_write_ex_q;
    mem_to_reg_wb_d  = mem_to_reg_mem_q;
    reg_write_wb_d   = reg_write_mem_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      reg_dst_ex_q     <= 1'b0;
      alu_src_ex_q     <= 1'b0;
      alu_op_ex_q      <= '0;
      rt_ex_q          <= '0;
      mem_read_ex_q    <= 1'b0;
      mem_write_ex_q   <= 1'b0;
      branch_ex_q      <= '0;
      mem_to_reg_ex_q  <= 1'b0;
      reg_write_ex_q   <= 1'b0;
      illegal_ex_q     <= 1'b0;
      mem_read_mem_q   <= 1'b0;
      mem_write_mem_q  <= 1'b0;
      branch_mem_q     <= '0;
      mem_to_reg_mem_q <= 1'b0;
      reg_write_mem_q  <= 1'b0;
      mem_to_reg_wb_q  <= 1'b0;
      reg_write_wb_q   <= 1'b0;
    end else begin
      reg_dst_ex_q     <= reg_dst_ex_d;
      alu_src_ex_q     <= alu_src_ex_d;
      alu_op_ex_q      <= alu_op_ex_d;
      rt_ex_q          <= rt_ex_d;
      mem_read_ex_q    <= mem_read_ex_d;
      mem_write_ex_q   <= mem_write_ex_d;
      branch_ex_q      <= branch_ex_d;
      mem_to_reg_ex_q  <= mem_to_reg_ex_d;
      reg_write_ex_q   <= reg_write_ex_d;
      illegal_ex_q     <= illegal_ex_d;
      mem_read_mem_q   <= mem_read_mem_d;
      mem_write_mem_q  <= mem_write_mem_d;
      branch_mem_q     <= branch_mem_d;
      mem_to_reg_mem_q <= mem_to_reg_mem_d;
      reg_write_mem_q  <= reg_write_mem_d;
      mem_to_reg_wb_q  <= mem_to_reg_wb_d;
      reg_write_wb_q   <= reg_write_wb_d;
    end
  end

  always_comb begin
    RegDst_EX    = reg_dst_ex_q;
    ALUSrc_EX    = alu_src_ex_q;
    ALUOp_EX     = alu_op_ex_q;
    Rt_EX        = rt_ex_q;
    IllegalOp    = illegal_ex_q;
    MemRead_MEM  = mem_read_mem_q;
    MemWrite_MEM = mem_write_mem_q;
    Branch_MEM   = branch_mem_q;
    MemtoReg_WB  = mem_to_reg_wb_q;
    RegWrite_WB  = reg_write_wb_q;
    Stall        = load_use;
  end

endmodule
